// File: rtl/hack_video_pkg.sv
// Shared constants for the Hack screen memory map and the default 512x256 video timing.
package hack_video_pkg;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int          WORDS_PER_ROW = 32;
  localparam int          SCREEN_ROWS   = 256;
  localparam int          SCREEN_WORDS  = 8192;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BP     = 80;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 17;

endpackage

// File: rtl/hack_video_timing.sv
// Horizontal/vertical position counters with combinational region, sync and blank decode.
module hack_video_timing
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_W      = 10,
  parameter int V_W      = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_pix,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hblank_c,
  output logic           vblank_c,
  output logic           hs_c,
  output logic           vs_c
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_START = H_W'(H_TOTAL - 3);
  localparam logic [H_W-1:0] H_ACT   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_ON   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_OFF  = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_ON   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_OFF  = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
    end
  end

  // Reset parks the counters just before row 0's word-0 fetch point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= H_START;
      v_q <= V_LAST;
    end else if (ce_pix) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h        = h_q;
  assign v        = v_q;
  assign hblank_c = !(h_q < H_ACT);
  assign vblank_c = !(v_q < V_ACT);
  assign hs_c     = (h_q >= HS_ON) && (h_q < HS_OFF);
  assign vs_c     = (v_q >= VS_ON) && (v_q < VS_OFF);

endmodule

// File: rtl/hack_screen_scanout.sv
// Reads Hack screen RAM one word ahead of the beam and serialises it into a 1 bpp pixel stream.
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [12:0] ram_addr,
  output logic        ram_rd,
  input  logic [15:0] ram_data,
  output logic        pixel,
  output logic        hs,
  output logic        vs,
  output logic        hblank,
  output logic        vblank,
  output logic        de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0] H_FETCH0 = H_W'(H_TOTAL - 3);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W:0]   W16      = (H_W+1)'(16);
  localparam logic [H_W:0]   ACT_X    = (H_W+1)'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           hblank_c, vblank_c, hs_c, vs_c, de_c;

  hack_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .h        (h),
    .v        (v),
    .hblank_c (hblank_c),
    .vblank_c (vblank_c),
    .hs_c     (hs_c),
    .vs_c     (vs_c)
  );

  logic [H_W:0]   h_p3, h_p1;
  logic           wrap_fetch, mid_fetch, load_pt;
  logic [V_W-1:0] fetch_row;
  logic [4:0]     fetch_word;
  logic [15:0]    shift_q, shift_d, next_word_q;
  logic           rd_pending_q;
  logic           pixel_q, hs_q, vs_q, hblank_q, vblank_q, de_q;

  // Word w is fetched two pixels before it must be loaded; word 0 comes from the tail of the previous line.
  always_comb begin
    h_p3       = {1'b0, h} + (H_W+1)'(3);
    h_p1       = {1'b0, h} + (H_W+1)'(1);
    wrap_fetch = (h == H_FETCH0);
    mid_fetch  = (h_p3[3:0] == 4'd0) && (h_p3 >= W16) && (h_p3 < ACT_X);
    fetch_row  = v;
    if (wrap_fetch) fetch_row = (v == V_LAST) ? '0 : v + V_W'(1);
    fetch_word = wrap_fetch ? 5'd0 : 5'(h_p3 >> 4);
    ram_rd     = ce_pix && !reset && (wrap_fetch || mid_fetch) && (fetch_row < V_ACT);
    ram_addr   = ram_rd ? {8'(fetch_row), fetch_word} : 13'd0;
    load_pt    = (h == H_LAST) ||
                 ((h_p1[3:0] == 4'd0) && (h_p1 >= W16) && (h_p1 < ACT_X));
    shift_d    = shift_q;
    if (load_pt)       shift_d = next_word_q;
    else if (!hblank_c) shift_d = shift_q >> 1;
    de_c       = !hblank_c && !vblank_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      next_word_q  <= '0;
      shift_q      <= '0;
      pixel_q      <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hblank_q     <= 1'b1;
      vblank_q     <= 1'b1;
      de_q         <= 1'b0;
    end else begin
      rd_pending_q <= ram_rd;
      if (rd_pending_q) next_word_q <= ram_data;
      if (ce_pix) begin
        shift_q  <= shift_d;
        pixel_q  <= de_c && shift_q[0];
        hs_q     <= hs_c;
        vs_q     <= vs_c;
        hblank_q <= hblank_c;
        vblank_q <= vblank_c;
        de_q     <= de_c;
      end
    end
  end

  assign pixel  = pixel_q;
  assign hs     = hs_q;
  assign vs     = vs_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign de     = de_q;

endmodule
